// File: rtl/cpu_pkg.sv
// Shared definitions for the bit-serial CPU: instruction geometry,
// opcode constants and the instruction loader state encoding.
package cpu_pkg;

    localparam int INST_W = 12;
    localparam int CNT_W  = $clog2(INST_W + 1);

    localparam logic [3:0] OPC_ADD  = 4'b0000;
    localparam logic [3:0] OPC_SUB  = 4'b0001;
    localparam logic [3:0] OPC_OR   = 4'b0100;
    localparam logic [3:0] OPC_AND  = 4'b0101;
    localparam logic [3:0] OPC_XOR  = 4'b0110;
    localparam logic [3:0] OPC_ADDI = 4'b1000;
    localparam logic [3:0] OPC_SUBI = 4'b1001;
    localparam logic [3:0] OPC_ORI  = 4'b1010;
    localparam logic [3:0] OPC_ANDI = 4'b1011;
    localparam logic [3:0] OPC_XORI = 4'b1100;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        READY = 2'd1,
        BUSY  = 2'd2
    } ld_state_t;

endpackage

// File: rtl/inst_loader_if.sv
// Front-panel bundle between the operator controls, the loader and
// the execute side.
interface inst_loader_if;
    import cpu_pkg::*;

    logic              btn_raw;
    logic              bit_raw;
    logic              clr_inst;
    logic              exec_done;
    logic [INST_W-1:0] instr;
    logic [3:0]        opcode;
    logic [INST_W-5:0] imm;
    logic              inst_done;
    logic              btn_edge;
    logic              busy;
    logic [CNT_W-1:0]  bit_cnt;

    modport master (
        output btn_raw, bit_raw, clr_inst, exec_done,
        input  instr, opcode, imm, inst_done, btn_edge, busy, bit_cnt
    );

    modport slave (
        input  btn_raw, bit_raw, clr_inst, exec_done,
        output instr, opcode, imm, inst_done, btn_edge, busy, bit_cnt
    );

endinterface

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: synchronizer, stability counter and a
// one-cycle pulse on each accepted press.
module btn_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_q;
    logic [15:0]            cnt_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press   <= 1'b0;
        end else begin
            sync_q[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            press <= 1'b0;
            if (synced == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
                // Only a 0->1 flip of the level counts as a press
                level_q <= synced;
                cnt_q   <= '0;
                press   <= synced;
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Operator front end: shifts in one instruction bit per press, then
// turns the next press into the execute trigger.
module inst_loader #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          SYNC_STAGES     = 2
) (
    input logic         clk,
    input logic         rst,
    inst_loader_if.slave bus
);
    import cpu_pkg::*;

    logic                   press;
    logic [SYNC_STAGES-1:0] bit_q;
    logic                   bit_s;

    ld_state_t         state_q, state_nx;
    logic [INST_W-1:0] instr_q, instr_nx;
    logic [CNT_W-1:0]  cnt_q, cnt_nx;
    logic              done_q, done_nx;
    logic              busy_q, busy_nx;
    logic              trig_q, trig_nx;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_btn (
        .clk  (clk),
        .rst  (rst),
        .raw  (bus.btn_raw),
        .press(press)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_q <= '0;
        end else begin
            bit_q[0] <= bus.bit_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                bit_q[i] <= bit_q[i-1];
            end
        end
    end

    assign bit_s = bit_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            instr_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_nx;
            instr_q <= instr_nx;
            cnt_q   <= cnt_nx;
            done_q  <= done_nx;
            busy_q  <= busy_nx;
            trig_q  <= trig_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        instr_nx = instr_q;
        cnt_nx   = cnt_q;
        done_nx  = done_q;
        busy_nx  = busy_q;
        trig_nx  = 1'b0;
        // Abort wins over any press or completion in the same cycle
        if (bus.clr_inst) begin
            state_nx = LOAD;
            cnt_nx   = '0;
            done_nx  = 1'b0;
            busy_nx  = 1'b0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (press) begin
                        instr_nx = {bit_s, instr_q[INST_W-1:1]};
                        cnt_nx   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(INST_W - 1)) begin
                            state_nx = READY;
                            done_nx  = 1'b1;
                        end
                    end
                end
                READY: begin
                    if (press) begin
                        state_nx = BUSY;
                        busy_nx  = 1'b1;
                        trig_nx  = 1'b1;
                    end
                end
                BUSY: begin
                    if (bus.exec_done) begin
                        state_nx = LOAD;
                        cnt_nx   = '0;
                        done_nx  = 1'b0;
                        busy_nx  = 1'b0;
                    end
                end
                default: state_nx = LOAD;
            endcase
        end
    end

    assign bus.instr     = instr_q;
    assign bus.opcode    = instr_q[3:0];
    assign bus.imm       = instr_q[INST_W-1:4];
    assign bus.bit_cnt   = cnt_q;
    assign bus.inst_done = done_q;
    assign bus.busy      = busy_q;
    assign bus.btn_edge  = trig_q;

endmodule

// File: tb/tb_inst_loader.sv
// Randomised scoreboard bench for inst_loader with a short debounce
// window; every visible output change is matched against the model.
module tb_inst_loader;
    import cpu_pkg::*;

    localparam logic [15:0] DB  = 16'd4;
    localparam int          SS  = 2;
    localparam int          LAT = SS + int'(DB);
    localparam int          TW  = INST_W + CNT_W + 3;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    inst_loader_if bus();

    inst_loader #(
        .DEBOUNCE_CYCLES(DB),
        .SYNC_STAGES    (SS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [TW-1:0]     exp_q[$];
    logic [INST_W-1:0] m_instr = '0;
    int                m_cnt   = 0;
    bit                m_busy  = 1'b0;

    function automatic logic [TW-1:0] pack(logic [INST_W-1:0] i, int c,
                                           bit d, bit b, bit e);
        return {i, CNT_W'(c), d, b, e};
    endfunction

    function automatic logic [TW-1:0] cur_model();
        return pack(m_instr, m_cnt, m_cnt == INST_W, m_busy, 1'b0);
    endfunction

    function automatic logic [TW-1:0] dut_tuple();
        return {bus.instr, bus.bit_cnt, bus.inst_done, bus.busy, bus.btn_edge};
    endfunction

    task automatic m_press(bit b);
        if (m_busy) return;
        if (m_cnt == INST_W) begin
            m_busy = 1'b1;
            exp_q.push_back(pack(m_instr, m_cnt, 1'b1, 1'b1, 1'b1));
            exp_q.push_back(pack(m_instr, m_cnt, 1'b1, 1'b1, 1'b0));
        end else begin
            m_instr = (m_instr >> 1) | (INST_W'(b) << (INST_W - 1));
            m_cnt++;
            exp_q.push_back(cur_model());
        end
    endtask

    task automatic m_clear(bit full);
        logic [TW-1:0] old;
        old    = cur_model();
        m_cnt  = 0;
        m_busy = 1'b0;
        if (full) m_instr = '0;
        if (cur_model() != old) exp_q.push_back(cur_model());
    endtask

    task automatic m_exec();
        if (!m_busy) return;
        m_busy = 1'b0;
        m_cnt  = 0;
        exp_q.push_back(cur_model());
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // mode 0: plain press, 1: clr_inst on the press cycle, 2: exec_done on it
    task automatic press(bit b, int mode, int hold);
        bus.bit_raw = b;
        bus.btn_raw = 1'b1;
        if (mode == 1) m_clear(1'b0);
        else if (mode == 2 && m_busy) m_exec();
        else m_press(b);
        repeat (LAT) @(posedge clk);
        #1;
        if (mode == 1) bus.clr_inst = 1'b1;
        if (mode == 2) bus.exec_done = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_inst  = 1'b0;
        bus.exec_done = 1'b0;
        repeat (hold + 2) @(posedge clk);
        #1;
        bus.btn_raw = 1'b0;
        repeat (LAT + 4) @(posedge clk);
        #1;
    endtask

    task automatic load_word(logic [INST_W-1:0] v);
        for (int i = 0; i < INST_W; i++) press(v[i], 0, 0);
    endtask

    task automatic exec_pulse();
        m_exec();
        bus.exec_done = 1'b1;
        @(posedge clk);
        #1;
        bus.exec_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clr_pulse();
        m_clear(1'b0);
        bus.clr_inst = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_inst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(string name);
        m_clear(1'b1);
        rst = 1'b1;
        #1;
        check(name, 32'(dut_tuple()), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [TW-1:0] prev, cur, e;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = dut_tuple();
            if (cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change got=%h", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        errors++;
                        $display("FAIL event got=%h exp=%h", cur, e);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        logic [INST_W-1:0] v;
        logic [11:0]       addi_bits;

        rst           = 1'b1;
        bus.btn_raw   = 1'b0;
        bus.bit_raw   = 1'b0;
        bus.clr_inst  = 1'b0;
        bus.exec_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 32'(dut_tuple()), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        addi_bits = 12'b001110101000;
        load_word(addi_bits);
        check("addi_instr", 32'(bus.instr), 32'h3A8);
        check("addi_opcode", 32'(bus.opcode), 32'(OPC_ADDI));
        check("addi_imm", 32'(bus.imm), 32'h3A);
        check("addi_done", 32'(bus.inst_done), 32'd1);
        check("addi_cnt", 32'(bus.bit_cnt), 32'd12);

        press(1'b1, 0, 0);
        check("exec_busy", 32'(bus.busy), 32'd1);
        press(1'b0, 0, 0);
        press(1'b1, 0, 0);
        check("busy_instr_stable", 32'(bus.instr), 32'h3A8);
        exec_pulse();
        check("after_exec", 32'({bus.inst_done, bus.busy, bus.bit_cnt}), 32'd0);

        bus.bit_raw = 1'b1;
        m_press(1'b1);
        for (int i = 0; i < 10; i++) begin
            bus.btn_raw = (i % 2 == 0);
            repeat (2) @(posedge clk);
            #1;
        end
        bus.btn_raw = 1'b1;
        repeat (LAT + 6) @(posedge clk);
        #1;
        bus.btn_raw = 1'b0;
        repeat (LAT + 4) @(posedge clk);
        #1;
        check("bounce_one_bit", 32'(bus.bit_cnt), 32'd1);
        bus.btn_raw = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.btn_raw = 1'b0;
        repeat (LAT + 6) @(posedge clk);
        #1;
        check("glitch_no_press", 32'(bus.bit_cnt), 32'd1);

        for (int i = 0; i < 4; i++) press(1'($urandom_range(0, 1)), 0, 0);
        check("five_bits", 32'(bus.bit_cnt), 32'd5);
        press(1'b1, 1, 0);
        check("abort_cnt", 32'(bus.bit_cnt), 32'd0);
        check("abort_no_done", 32'(bus.inst_done), 32'd0);
        v = {8'($urandom), OPC_XOR};
        load_word(v);
        check("xor_opcode", 32'(bus.opcode), 32'(OPC_XOR));
        check("xor_instr", 32'(bus.instr), 32'(v));

        press(1'b0, 0, 0);
        press(1'b1, 2, 0);
        check("collide_cnt", 32'(bus.bit_cnt), 32'd0);
        check("collide_busy", 32'(bus.busy), 32'd0);
        load_word(INST_W'($urandom));
        press(1'b1, 0, 30);
        check("held_busy", 32'(bus.busy), 32'd1);
        exec_pulse();

        for (int i = 0; i < 7; i++) press(1'($urandom_range(0, 1)), 0, 0);
        check("seven_bits", 32'(bus.bit_cnt), 32'd7);
        do_reset("rst_midload");
        load_word(INST_W'($urandom));
        press(1'b0, 0, 0);
        do_reset("rst_busy");
        v = INST_W'($urandom);
        load_word(v);
        check("post_rst_instr", 32'(bus.instr), 32'(v));
        check("post_rst_done", 32'(bus.inst_done), 32'd1);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                7:       exec_pulse();
                8:       clr_pulse();
                9:       press(1'($urandom_range(0, 1)), 2, 0);
                default: press(1'($urandom_range(0, 1)), 0, 0);
            endcase
        end
        check("rand_instr", 32'(bus.instr), 32'(m_instr));
        check("rand_cnt", 32'(bus.bit_cnt), 32'(m_cnt));

        repeat (20) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
